// File: rtl/cache_pkg.sv
// Shared types and address-field helpers for the cache_level hierarchy block.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    FILL_REQ,
    FILL_GAP,
    COMPLETE,
    WAIT_DROP
  } state_t;

  // Bits needed to index n items; a single item needs no field at all.
  function automatic int unsigned field_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 0;
  endfunction

  // Physical vector width for a field that may be zero bits wide.
  function automatic int unsigned vec_w(input int unsigned w);
    return (w > 0) ? w : 1;
  endfunction

  function automatic logic [31:0] addr_offset(input logic [31:0] a, input int unsigned wpb);
    return a & (wpb - 1);
  endfunction

  function automatic logic [31:0] addr_index(input logic [31:0] a, input int unsigned wpb,
                                             input int unsigned sets);
    return (a >> field_w(wpb)) & (sets - 1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] a, input int unsigned wpb,
                                           input int unsigned sets);
    return a >> (field_w(wpb) + field_w(sets));
  endfunction

endpackage

// File: rtl/cache_level_array.sv
// Valid/tag/data storage for one cache level: combinational read of all ways
// of a set, single write port; only the valid bits are reset.
module cache_level_array
  import cache_pkg::*;
#(
  parameter  int unsigned DATA_W          = 32,
  parameter  int unsigned TAG_W           = 13,
  parameter  int unsigned WORDS_PER_BLOCK = 2,
  parameter  int unsigned SETS            = 4,
  parameter  int unsigned WAYS            = 2,
  localparam int unsigned IDX_WS          = vec_w(field_w(SETS)),
  localparam int unsigned WAY_WS          = vec_w(field_w(WAYS)),
  localparam int unsigned OFF_WS          = vec_w(field_w(WORDS_PER_BLOCK))
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic [IDX_WS-1:0]                             rd_index,
  output logic [WAYS-1:0]                               rd_valid,
  output logic [WAYS-1:0][TAG_W-1:0]                    rd_tag,
  output logic [WAYS-1:0][WORDS_PER_BLOCK-1:0][DATA_W-1:0] rd_data,
  input  logic [IDX_WS-1:0]                             wr_index,
  input  logic [WAY_WS-1:0]                             wr_way,
  input  logic [OFF_WS-1:0]                             wr_word,
  input  logic                                          data_we,
  input  logic [DATA_W-1:0]                             wr_data,
  input  logic                                          tag_we,
  input  logic [TAG_W-1:0]                              wr_tag,
  input  logic                                          vld_we,
  input  logic                                          vld_val
);

  logic [SETS-1:0][WAYS-1:0] valid_q, valid_d;
  logic [WAYS-1:0][TAG_W-1:0] tag_q [SETS];
  logic [WAYS-1:0][TAG_W-1:0] tag_d [SETS];
  logic [WAYS-1:0][WORDS_PER_BLOCK-1:0][DATA_W-1:0] data_q [SETS];
  logic [WAYS-1:0][WORDS_PER_BLOCK-1:0][DATA_W-1:0] data_d [SETS];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (vld_we)  valid_d[wr_index][wr_way]        = vld_val;
    if (tag_we)  tag_d[wr_index][wr_way]          = wr_tag;
    if (data_we) data_d[wr_index][wr_way][wr_word] = wr_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  always_ff @(posedge clock) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/cache_level.sv
// One level of the cache hierarchy: set-associative, FIFO-replacement, read-only.
// Define CACHE_LEVEL_STATS_EN to add saturating hitCount/missCount outputs.
module cache_level
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W          = 16,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned WORDS_PER_BLOCK = 2,
  parameter int unsigned SETS            = 4,
  parameter int unsigned WAYS            = 2,
  parameter int unsigned HIT_DELAY       = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              enable,
  output logic              requestComplete,
  output logic [DATA_W-1:0] dataOut,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_enable,
  input  logic              mem_requestComplete,
  input  logic [DATA_W-1:0] mem_dataIn
`ifdef CACHE_LEVEL_STATS_EN
  ,
  output logic [31:0]       hitCount,
  output logic [31:0]       missCount
`endif
);

  localparam int unsigned OFF_W  = field_w(WORDS_PER_BLOCK);
  localparam int unsigned IDX_W  = field_w(SETS);
  localparam int unsigned TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int unsigned OFF_WS = vec_w(OFF_W);
  localparam int unsigned IDX_WS = vec_w(IDX_W);
  localparam int unsigned WAY_WS = vec_w(field_w(WAYS));
  localparam int unsigned CNT_W  = vec_w(field_w(HIT_DELAY));

  state_t                          state_q, state_d;
  logic [ADDR_W-1:0]               req_addr_q, req_addr_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [OFF_WS-1:0]               word_q, word_d;
  logic [WAY_WS-1:0]               way_q, way_d;
  logic [SETS-1:0][WAY_WS-1:0]     fifo_ptr_q, fifo_ptr_d;
  logic [DATA_W-1:0]               dout_q, dout_d;

  logic [OFF_WS-1:0]               req_off;
  logic [IDX_WS-1:0]               req_idx;
  logic [TAG_W-1:0]                req_tag;

  logic [WAYS-1:0]                 rd_valid;
  logic [WAYS-1:0][TAG_W-1:0]      rd_tag;
  logic [WAYS-1:0][WORDS_PER_BLOCK-1:0][DATA_W-1:0] rd_data;

  logic                            hit;
  logic [WAY_WS-1:0]               hit_way;
  logic [WAY_WS-1:0]               wr_way;
  logic                            data_we, tag_we, vld_we, vld_val;

  assign req_off = OFF_WS'(addr_offset(32'(req_addr_q), WORDS_PER_BLOCK));
  assign req_idx = IDX_WS'(addr_index(32'(req_addr_q), WORDS_PER_BLOCK, SETS));
  assign req_tag = TAG_W'(addr_tag(32'(req_addr_q), WORDS_PER_BLOCK, SETS));

  cache_level_array #(
    .DATA_W          (DATA_W),
    .TAG_W           (TAG_W),
    .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
    .SETS            (SETS),
    .WAYS            (WAYS)
  ) u_array (
    .clock    (clock),
    .reset    (reset),
    .rd_index (req_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_index (req_idx),
    .wr_way   (wr_way),
    .wr_word  (word_q),
    .data_we  (data_we),
    .wr_data  (mem_dataIn),
    .tag_we   (tag_we),
    .wr_tag   (req_tag),
    .vld_we   (vld_we),
    .vld_val  (vld_val)
  );

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (rd_valid[w] && (rd_tag[w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_WS'(w);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    way_d      = way_q;
    fifo_ptr_d = fifo_ptr_q;
    dout_d     = dout_q;
    wr_way     = way_q;
    data_we    = 1'b0;
    tag_we     = 1'b0;
    vld_we     = 1'b0;
    vld_val    = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          req_addr_d = addr;
          cnt_d      = CNT_W'(HIT_DELAY - 1);
          state_d    = LOOKUP;
        end
      end
      LOOKUP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (hit) begin
          way_d   = hit_way;
          dout_d  = rd_data[hit_way][req_off];
          state_d = COMPLETE;
        end else begin
          // Victim is invalidated up front so an abandoned fill never leaves a stale block.
          way_d   = fifo_ptr_q[req_idx];
          wr_way  = fifo_ptr_q[req_idx];
          vld_we  = 1'b1;
          word_d  = '0;
          state_d = FILL_REQ;
        end
      end
      FILL_REQ: begin
        if (mem_requestComplete) begin
          data_we = 1'b1;
          state_d = FILL_GAP;
        end
      end
      FILL_GAP: begin
        if (word_q == OFF_WS'(WORDS_PER_BLOCK - 1)) begin
          vld_we  = 1'b1;
          vld_val = 1'b1;
          tag_we  = 1'b1;
          fifo_ptr_d[req_idx] = (fifo_ptr_q[req_idx] == WAY_WS'(WAYS - 1)) ?
                                '0 : fifo_ptr_q[req_idx] + 1'b1;
          dout_d  = rd_data[way_q][req_off];
          state_d = COMPLETE;
        end else begin
          word_d  = word_q + 1'b1;
          state_d = FILL_REQ;
        end
      end
      COMPLETE:  state_d = WAIT_DROP;
      WAIT_DROP: if (!enable) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      cnt_q      <= '0;
      word_q     <= '0;
      way_q      <= '0;
      fifo_ptr_q <= '0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      way_q      <= way_d;
      fifo_ptr_q <= fifo_ptr_d;
      dout_q     <= dout_d;
    end
  end

  assign requestComplete = (state_q == COMPLETE);
  assign dataOut         = dout_q;
  assign mem_enable      = (state_q == FILL_REQ);
  assign mem_addr        = mem_enable ?
                           ((req_addr_q & ~ADDR_W'(WORDS_PER_BLOCK - 1)) | ADDR_W'(word_q)) : '0;

`ifdef CACHE_LEVEL_STATS_EN
  logic        resolve, hit_evt, miss_evt;
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  assign resolve  = (state_q == LOOKUP) && (cnt_q == '0);
  assign hit_evt  = resolve && hit;
  assign miss_evt = resolve && !hit;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit_evt && (hit_cnt_q != '1))   hit_cnt_d  = hit_cnt_q + 32'd1;
    if (miss_evt && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hitCount  = hit_cnt_q;
  assign missCount = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_level.sv
// Self-checking bench for cache_level: FIFO-order set model plus a delayed backing memory.
`timescale 1ns/1ps
module tb_cache_level;

  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned WPB       = 2;
  localparam int unsigned SETS      = 4;
  localparam int unsigned WAYS      = 2;
  localparam int unsigned HIT_DELAY = 1;
  localparam int unsigned MEM_DELAY = 10;
  localparam int unsigned HIT_LAT   = HIT_DELAY + 1;
  localparam int unsigned MISS_LAT  = HIT_DELAY + 1 + WPB * (MEM_DELAY + 1);

  logic              clock;
  logic              reset;
  logic [ADDR_W-1:0] addr;
  logic              enable;
  logic              requestComplete;
  logic [DATA_W-1:0] dataOut;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_enable;
  logic              mem_requestComplete;
  logic [DATA_W-1:0] mem_dataIn;
`ifdef CACHE_LEVEL_STATS_EN
  logic [31:0]       hitCount;
  logic [31:0]       missCount;
`endif

  cache_level #(
    .ADDR_W          (ADDR_W),
    .DATA_W          (DATA_W),
    .WORDS_PER_BLOCK (WPB),
    .SETS            (SETS),
    .WAYS            (WAYS),
    .HIT_DELAY       (HIT_DELAY)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .addr                (addr),
    .enable              (enable),
    .requestComplete     (requestComplete),
    .dataOut             (dataOut),
    .mem_addr            (mem_addr),
    .mem_enable          (mem_enable),
    .mem_requestComplete (mem_requestComplete),
    .mem_dataIn          (mem_dataIn)
`ifdef CACHE_LEVEL_STATS_EN
    ,
    .hitCount            (hitCount),
    .missCount           (missCount)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {~a, a};
  endfunction

  // ---------------- behavioural cache model ----------------
  int unsigned set_q [SETS][$];
  int unsigned m_hits, m_misses;
  bit          pend, pend_miss;
  int unsigned pend_cyc;
  logic [15:0] pend_addr;
  logic [31:0] pend_data, exp_dout;

  function automatic bit model_access(input logic [15:0] a);
    int unsigned blk = int'(a) / WPB;
    int unsigned s   = blk % SETS;
    int unsigned tag = blk / SETS;
    foreach (set_q[s][i]) begin
      if (set_q[s][i] == tag) begin
        m_hits++;
        return 1'b1;
      end
    end
    if (set_q[s].size() == WAYS) void'(set_q[s].pop_front());
    set_q[s].push_back(tag);
    m_misses++;
    return 1'b0;
  endfunction

  function automatic void model_clear();
    foreach (set_q[i]) set_q[i].delete();
    m_hits   = 0;
    m_misses = 0;
    pend     = 1'b0;
    exp_dout = '0;
  endfunction

  // ---------------- backing memory ----------------
  bit          spur_req = 1'b0;
  bit          served   = 1'b0;
  int unsigned mem_cnt  = 0;

  initial begin
    mem_requestComplete = 1'b0;
    mem_dataIn          = '0;
    forever begin
      @(posedge clock); #1;
      mem_requestComplete = 1'b0;
      if (spur_req) begin
        mem_requestComplete = 1'b1;
        mem_dataIn          = 32'hDEAD_BEEF;
        spur_req            = 1'b0;
      end else if (mem_enable && !served) begin
        mem_cnt++;
        if (mem_cnt == MEM_DELAY) begin
          mem_requestComplete = 1'b1;
          mem_dataIn          = mem_word(mem_addr);
          served              = 1'b1;
          mem_cnt             = 0;
        end
      end else if (!mem_enable) begin
        mem_cnt = 0;
        served  = 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int unsigned rc_pulses = 0;
  int unsigned rc_seen_cyc = 0;
  logic [15:0] mem_log[$];
  int unsigned rise_cyc[$];
  int unsigned fall_cyc[$];
  bit          mem_en_prev = 1'b0;

  always @(negedge clock) begin
    bit exp_rc;
    if (!reset) begin
      check("reset_requestComplete", 64'(requestComplete), 64'd0);
      check("reset_dataOut", 64'(dataOut), 64'd0);
      check("reset_mem_enable", 64'(mem_enable), 64'd0);
      check("reset_mem_addr", 64'(mem_addr), 64'd0);
      mem_en_prev = 1'b0;
    end else begin
      exp_rc = pend && (cyc == pend_cyc);
      check("requestComplete", 64'(requestComplete), 64'(exp_rc));
      if (requestComplete) begin
        rc_pulses++;
        rc_seen_cyc = cyc;
      end
      if (exp_rc) begin
        exp_dout = pend_data;
        pend     = 1'b0;
      end
      check("dataOut", 64'(dataOut), 64'(exp_dout));
      if (!(pend && pend_miss)) check("mem_enable_quiet", 64'(mem_enable), 64'd0);
      else if (mem_enable) check("mem_addr_block", 64'(mem_addr / WPB), 64'(pend_addr / WPB));
      if (mem_enable && !mem_en_prev) begin
        mem_log.push_back(mem_addr);
        rise_cyc.push_back(cyc);
      end
      if (!mem_enable && mem_en_prev) fall_cyc.push_back(cyc);
      mem_en_prev = mem_enable;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_req(input logic [15:0] a, output int unsigned k);
    bit hit;
    hit       = model_access(a);
    k         = cyc;
    pend_miss = !hit;
    pend_addr = a;
    pend_data = mem_word(a);
    pend_cyc  = k + (hit ? HIT_LAT : MISS_LAT);
    pend      = 1'b1;
    addr      = a;
    enable    = 1'b1;
  endtask

  task automatic do_read(input logic [15:0] a, input int unsigned drop_at,
                         input int unsigned hold, output int unsigned lat,
                         output logic [31:0] data);
    int unsigned k, p0, n;
    @(posedge clock); #2;
    p0 = rc_pulses;
    start_req(a, k);
    n = 0;
    while (rc_pulses == p0 && n < 200) begin
      @(posedge clock); #2;
      n++;
      if (drop_at != 0 && n == drop_at) enable = 1'b0;
    end
    lat  = 0;
    data = '0;
    if (rc_pulses == p0) begin
      check("read_timeout", 64'(rc_pulses - p0), 64'd1);
      pend = 1'b0;
    end else begin
      lat  = rc_seen_cyc - k;
      data = dataOut;
    end
    repeat (hold) begin
      @(posedge clock); #2;
    end
    enable = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clock); #2;
    reset  = 1'b0;
    enable = 1'b0;
    #1;
    check("async_reset_mem_enable", 64'(mem_enable), 64'd0);
    check("async_reset_requestComplete", 64'(requestComplete), 64'd0);
    check("async_reset_dataOut", 64'(dataOut), 64'd0);
    model_clear();
    repeat (2) begin
      @(posedge clock); #2;
    end
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int unsigned lat, k, n, p0, sz0;
    logic [31:0] d;
    reset  = 1'b0;
    enable = 1'b0;
    addr   = '0;
    model_clear();
    apply_reset();

    do_read(16'd0, 0, 0, lat, d);
    check("first_read0_latency", 64'(lat), 64'd24);
    check("first_read0_data", 64'(d), 64'hFFFF_0000);
    do_read(16'd0, 0, 0, lat, d);
    check("second_read0_hit_latency", 64'(lat), 64'd2);
    do_read(16'd1, 0, 0, lat, d);
    check("read1_same_block_latency", 64'(lat), 64'd2);
    check("read1_data", 64'(d), 64'hFFFE_0001);

    mem_log.delete(); rise_cyc.delete(); fall_cyc.delete();
    do_read(16'd2, 0, 0, lat, d);
    check("read2_miss_latency", 64'(lat), 64'd24);
    check("read2_pulse_count", 64'(mem_log.size()), 64'd2);
    if (mem_log.size() == 2 && fall_cyc.size() >= 1) begin
      check("read2_fill_addr0", 64'(mem_log[0]), 64'd2);
      check("read2_fill_addr1", 64'(mem_log[1]), 64'd3);
      check("read2_gap_cycles", 64'(rise_cyc[1] - fall_cyc[0]), 64'd1);
    end

    do_read(16'd8, 0, 0, lat, d);
    check("read8_miss_latency", 64'(lat), 64'd24);
    do_read(16'd16, 0, 0, lat, d);
    check("read16_evicts0_latency", 64'(lat), 64'd24);
    do_read(16'd8, 0, 0, lat, d);
    check("read8_still_hit", 64'(lat), 64'd2);
    do_read(16'd0, 0, 0, lat, d);
    check("read0_after_evict_miss", 64'(lat), 64'd24);

    mem_log.delete();
    p0 = rc_pulses;
    do_read(16'd16, 0, 20, lat, d);
    repeat (3) begin
      @(posedge clock); #2;
    end
    check("held_enable_pulses", 64'(rc_pulses - p0), 64'd1);
    check("held_enable_no_fill", 64'(mem_log.size()), 64'd0);

    do_read(16'd17, 1, 0, lat, d);
    check("drop_mid_lookup_latency", 64'(lat), 64'd2);
    check("drop_mid_lookup_data", 64'(d), 64'hFFEE_0011);
    do_read(16'd32, 5, 0, lat, d);
    check("drop_mid_fill_latency", 64'(lat), 64'd24);

    mem_log.delete();
    do_read(16'hFFFF, 0, 0, lat, d);
    check("top_addr_data", 64'(d), 64'h0000_FFFF);
    check("top_addr_pulses", 64'(mem_log.size()), 64'd2);
    if (mem_log.size() == 2) begin
      check("top_addr_fill0", 64'(mem_log[0]), 64'hFFFE);
      check("top_addr_fill1", 64'(mem_log[1]), 64'hFFFF);
    end

    p0 = rc_pulses;
    @(posedge clock); #2;
    spur_req = 1'b1;
    repeat (4) begin
      @(posedge clock); #2;
    end
    check("spurious_mem_complete_ignored", 64'(rc_pulses - p0), 64'd0);
    do_read(16'd1, 0, 0, lat, d);
    check("after_spurious_hit_latency", 64'(lat), 64'd2);
    check("after_spurious_data", 64'(d), 64'hFFFE_0001);

    // reset while the second word of a fill is outstanding
    @(posedge clock); #2;
    sz0 = mem_log.size();
    start_req(16'd4, k);
    n = 0;
    while (mem_log.size() < sz0 + 2 && n < 100) begin
      @(posedge clock); #2;
      n++;
    end
    check("midfill_second_request_seen", 64'(mem_log.size() - sz0), 64'd2);
    check("midfill_mem_enable_before_reset", 64'(mem_enable), 64'd1);
    apply_reset();
    do_read(16'd4, 0, 0, lat, d);
    check("reread_after_reset_latency", 64'(lat), 64'd24);
    check("reread_after_reset_data", 64'(d), 64'hFFFB_0004);

`ifdef CACHE_LEVEL_STATS_EN
    apply_reset();
    check("stats_reset_hits", 64'(hitCount), 64'd0);
    check("stats_reset_misses", 64'(missCount), 64'd0);
    do_read(16'd0, 0, 0, lat, d);
    do_read(16'd0, 0, 0, lat, d);
    do_read(16'd2, 0, 0, lat, d);
    do_read(16'd0, 0, 0, lat, d);
    @(posedge clock); #2;
    check("stats_hits", 64'(hitCount), 64'd2);
    check("stats_misses", 64'(missCount), 64'd2);
    check("stats_hits_model", 64'(hitCount), 64'(m_hits));
    check("stats_misses_model", 64'(missCount), 64'(m_misses));
`endif

    repeat (3) begin
      @(posedge clock); #2;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
